// File: rtl/ad80305_pkg.sv
// Shared AD80305 LVDS interface definitions (TX and RX sides).
`default_nettype none

package ad80305_pkg;

  localparam int IQ_W   = 12;
  localparam int HALF_W = 6;
  localparam int SAMP_W = 2 * IQ_W;

  localparam logic FRAME_MSB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } tx_state_t;

  function automatic logic [HALF_W:0] ddr_word(input logic frame, input logic [HALF_W-1:0] half);
    return {frame, half};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad_sync_fifo.sv
// Single-clock FIFO with registered occupancy; a pop frees room for a push in the same cycle.
`default_nettype none

module ad_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/ad80305_tx_if_ddr_lvds_td.sv
// AD80305 DDR LVDS transmit formatter: FIFO-buffered I/Q split into framed MSB/LSB words.
// Optional test ramp source enabled by defining AD_TX_RAMP_EN.
`default_nettype none

module ad80305_tx_if_ddr_lvds_td
  import ad80305_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int PRIME_LEVEL = 2
) (
  input  logic              i_fpga_clk_125p,
  input  logic              i_fpga_rst_125p,
  input  logic              i_tx_en,
  input  logic              i_iqdata_fp,
  input  logic [IQ_W-1:0]   i_idata,
  input  logic [IQ_W-1:0]   i_qdata,
  input  logic              i_clr_flags,
`ifdef AD_TX_RAMP_EN
  input  logic              i_ramp_sel,
`endif
  output logic [HALF_W:0]   o_ddr_h,
  output logic [HALF_W:0]   o_ddr_l,
  output logic [FIFO_AW:0]  o_fifo_level,
  output logic              o_underflow,
  output logic              o_overflow,
  output logic              o_running
);

  localparam int LVL_W = FIFO_AW + 1;

  tx_state_t         state;
  logic              phase;
  logic [SAMP_W-1:0] r_samp;
  logic [SAMP_W-1:0] slot_samp;
  logic [SAMP_W-1:0] head;
  logic [LVL_W-1:0]  level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              flush;
  logic              msb_slot;
  logic              ramp_on;
  logic              underflow_evt;
  logic              overflow_evt;

`ifdef AD_TX_RAMP_EN
  logic [IQ_W-1:0] ramp_cnt;
  assign ramp_on = i_ramp_sel;
`else
  assign ramp_on = 1'b0;
`endif

  // PRIME performs the first MSB slot itself so the word lands one cycle after the level is met.
  assign msb_slot = i_tx_en &&
                    (((state == PRIME) && (level >= LVL_W'(PRIME_LEVEL))) ||
                     ((state == RUN) && !phase));

  assign push          = i_iqdata_fp && (state != IDLE);
  assign pop           = msb_slot && !ramp_on && !fifo_empty;
  assign flush         = (state == IDLE);
  assign underflow_evt = msb_slot && !ramp_on && fifo_empty;
  assign overflow_evt  = push && fifo_full && !pop;

  always_comb begin
    slot_samp = '0;
`ifdef AD_TX_RAMP_EN
    if (ramp_on) slot_samp = {~ramp_cnt, ramp_cnt};
    else
`endif
    if (!fifo_empty) slot_samp = head;
  end

  ad_sync_fifo #(
    .WIDTH (SAMP_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (i_fpga_clk_125p),
    .rst_n (i_fpga_rst_125p),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({i_qdata, i_idata}),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      state   <= IDLE;
      phase   <= 1'b0;
      r_samp  <= '0;
      o_ddr_h <= '0;
      o_ddr_l <= '0;
    end else if (msb_slot) begin
      state   <= RUN;
      phase   <= 1'b1;
      r_samp  <= slot_samp;
      o_ddr_h <= ddr_word(FRAME_MSB, slot_samp[SAMP_W-1 -: HALF_W]);
      o_ddr_l <= ddr_word(FRAME_MSB, slot_samp[IQ_W-1 -: HALF_W]);
    end else begin
      case (state)
        IDLE: begin
          phase   <= 1'b0;
          o_ddr_h <= '0;
          o_ddr_l <= '0;
          if (i_tx_en) state <= PRIME;
        end
        PRIME: begin
          o_ddr_h <= '0;
          o_ddr_l <= '0;
          if (!i_tx_en) state <= IDLE;
        end
        RUN: begin
          if (phase) begin
            // LSB half always completes, even when transmit is being stopped.
            phase   <= 1'b0;
            o_ddr_h <= ddr_word(~FRAME_MSB, r_samp[IQ_W +: HALF_W]);
            o_ddr_l <= ddr_word(~FRAME_MSB, r_samp[0 +: HALF_W]);
            if (!i_tx_en) state <= IDLE;
          end else begin
            o_ddr_h <= '0;
            o_ddr_l <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          phase   <= 1'b0;
          o_ddr_h <= '0;
          o_ddr_l <= '0;
        end
      endcase
    end
  end

`ifdef AD_TX_RAMP_EN
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p)           ramp_cnt <= '0;
    else if (state == IDLE)         ramp_cnt <= '0;
    else if (msb_slot && ramp_on)   ramp_cnt <= ramp_cnt + 1'b1;
  end
`endif

  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (underflow_evt)    o_underflow <= 1'b1;
      else if (i_clr_flags) o_underflow <= 1'b0;
      if (overflow_evt)     o_overflow  <= 1'b1;
      else if (i_clr_flags) o_overflow  <= 1'b0;
    end
  end

  assign o_fifo_level = level;
  assign o_running    = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_ad80305_tx_if_ddr_lvds_td.sv
// Self-checking bench for ad80305_tx_if_ddr_lvds_td (default and PRIME_LEVEL=8 instances).
`default_nettype none

module tb_ad80305_tx_if_ddr_lvds_td;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en, fp, clr;
  logic [11:0] idata, qdata;
  logic [6:0]  h, l;
  logic [3:0]  lvl;
  logic        uf, of, run;

  logic        tx8, fp8, clr8;
  logic [11:0] i8, q8;
  logic [6:0]  h8, l8;
  logic [3:0]  lvl8;
  logic        uf8, of8, run8;

`ifdef AD_TX_RAMP_EN
  logic ramp_sel;
  logic ramp_sel8;
`endif

  int total = 0;
  int bad   = 0;

  logic [23:0] expq [$];
  logic [23:0] exp8 [$];
  logic [6:0]  wh8 [$];
  logic [6:0]  wl8 [$];

  always #4 clk = ~clk;

  ad80305_tx_if_ddr_lvds_td dut (
    .i_fpga_clk_125p (clk),
    .i_fpga_rst_125p (rst_n),
    .i_tx_en         (tx_en),
    .i_iqdata_fp     (fp),
    .i_idata         (idata),
    .i_qdata         (qdata),
    .i_clr_flags     (clr),
`ifdef AD_TX_RAMP_EN
    .i_ramp_sel      (ramp_sel),
`endif
    .o_ddr_h         (h),
    .o_ddr_l         (l),
    .o_fifo_level    (lvl),
    .o_underflow     (uf),
    .o_overflow      (of),
    .o_running       (run)
  );

  ad80305_tx_if_ddr_lvds_td #(.FIFO_AW(3), .PRIME_LEVEL(8)) dut8 (
    .i_fpga_clk_125p (clk),
    .i_fpga_rst_125p (rst_n),
    .i_tx_en         (tx8),
    .i_iqdata_fp     (fp8),
    .i_idata         (i8),
    .i_qdata         (q8),
    .i_clr_flags     (clr8),
`ifdef AD_TX_RAMP_EN
    .i_ramp_sel      (ramp_sel8),
`endif
    .o_ddr_h         (h8),
    .o_ddr_l         (l8),
    .o_fifo_level    (lvl8),
    .o_underflow     (uf8),
    .o_overflow      (of8),
    .o_running       (run8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the word format: MSB half is value/64, LSB half is value mod 64.
  function automatic logic [6:0] msb_w(input logic [11:0] v);
    return {1'b1, 6'(v / 64)};
  endfunction

  function automatic logic [6:0] lsb_w(input logic [11:0] v);
    return {1'b0, 6'(v % 64)};
  endfunction

  task automatic wait_msb(input string tag);
    int n = 0;
    while (h[6] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'd0, h[6]}, 32'd1);
  endtask

  // Push n random samples every other cycle and compare the reassembled output stream.
  task automatic run_stream(input int n, input string tag);
    int          pushed = 0;
    int          got = 0;
    int          cyc = 0;
    bit          started = 0;
    bit          second = 0;
    logic [6:0]  mh = '0, ml = '0;
    logic [23:0] s, e;
    while (got < n && cyc < 4 * n + 40) begin
      if (cyc % 2 == 0 && pushed < n) begin
        s = 24'($urandom);
        fp = 1'b1; idata = s[11:0]; qdata = s[23:12];
        expq.push_back(s);
        pushed++;
      end else begin
        fp = 1'b0;
      end
      tick();
      cyc++;
      if (!started && h[6] === 1'b1) started = 1;
      if (started) begin
        if (!second) begin
          mh = h; ml = l; second = 1;
        end else begin
          second = 0;
          e = (expq.size() != 0) ? expq.pop_front() : 'x;
          check({tag, "_frame"}, {28'd0, mh[6], ml[6], h[6], l[6]}, 32'hC);
          check({tag, "_i"}, {20'd0, ml[5:0], l[5:0]}, {20'd0, e[11:0]});
          check({tag, "_q"}, {20'd0, mh[5:0], h[5:0]}, {20'd0, e[23:12]});
          got++;
        end
      end
    end
    fp = 1'b0;
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    logic [23:0] s, a;
    int          idx;
    rst_n = 1'b0; tx_en = 0; fp = 0; clr = 0; idata = 0; qdata = 0;
    tx8 = 0; fp8 = 0; clr8 = 0; i8 = 0; q8 = 0;
`ifdef AD_TX_RAMP_EN
    ramp_sel = 0; ramp_sel8 = 0;
`endif
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_h", h, 0);
    check("rst_l", l, 0);
    check("rst_lvl", lvl, 0);
    check("rst_uf", uf, 0);
    check("rst_of", of, 0);
    check("rst_run", run, 0);
    check("rst_h8", h8, 0);

    // Directed example words
    tx_en = 1; tick(); tick();
    fp = 1; idata = 12'hABC; qdata = 12'h123; tick();
    idata = 12'h456; qdata = 12'h789; tick();
    fp = 0;
    wait_msb("t1_start");
    check("t1_h0", h, 7'h44); check("t1_l0", l, 7'h6A); check("t1_run", run, 1);
    tick(); check("t1_h1", h, 7'h23); check("t1_l1", l, 7'h3C);
    tick(); check("t1_h2", h, 7'h5E); check("t1_l2", l, 7'h51);
    tick(); check("t1_h3", h, 7'h09); check("t1_l3", l, 7'h16);
    tx_en = 0; tick();
    check("t1_off_h", h, 0); check("t1_off_run", run, 0);
    tick();
    check("t1_lvl", lvl, 0); check("t1_uf", uf, 0);

    // Steady random stream
    tx_en = 1; tick();
    run_stream(1000, "t2");
    tx_en = 0; tick(); tick();
    check("t2_uf", uf, 0); check("t2_of", of, 0);
    check("t2_run", run, 0); check("t2_lvl", lvl, 0);

    // Starvation: cadence continues with zero sample, sticky underflow
    tx_en = 1; tick();
    run_stream(3, "t3");
    tick(); check("t3_uh_msb", h, 7'h40); check("t3_ul_msb", l, 7'h40);
    tick(); check("t3_uh_lsb", h, 7'h00); check("t3_ul_lsb", l, 7'h00);
    check("t3_uf", uf, 1);
    tick(); check("t3_cadence", h, 7'h40);
    tick(); check("t3_cadence2", h, 7'h00);
    tx_en = 0; tick();
    clr = 1; tick(); clr = 0;
    check("t3_uf_clr", uf, 0); check("t3_run", run, 0);

    // Overflow while priming the PRIME_LEVEL=8 instance
    tx8 = 1; tick(); tick();
    for (int k = 0; k < 12; k++) begin
      s = 24'($urandom);
      fp8 = 1; i8 = s[11:0]; q8 = s[23:12];
      if (k < 8) exp8.push_back(s);
      tick();
      wh8.push_back(h8); wl8.push_back(l8);
    end
    fp8 = 0;
    check("t4_of", of8, 1);
    check("t4_lvl", lvl8, 8);
    for (int k = 0; k < 16; k++) begin
      tick();
      wh8.push_back(h8); wl8.push_back(l8);
    end
    idx = 0;
    while (idx < wh8.size() && wh8[idx][6] !== 1'b1) idx++;
    check("t4_start", {31'd0, idx < 12}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      a = exp8[k];
      if (idx + 2 * k + 1 < wh8.size()) begin
        check("t4_hm", wh8[idx + 2 * k],     msb_w(a[23:12]));
        check("t4_lm", wl8[idx + 2 * k],     msb_w(a[11:0]));
        check("t4_hl", wh8[idx + 2 * k + 1], lsb_w(a[23:12]));
        check("t4_ll", wl8[idx + 2 * k + 1], lsb_w(a[11:0]));
      end else begin
        check("t4_short", 32'd0, 32'd1);
      end
    end
    tx8 = 0; tick(); tick(); tick();
    check("t4_lvl0", lvl8, 0); check("t4_run0", run8, 0); check("t4_h0", h8, 0);
    clr8 = 1; tick(); clr8 = 0;
    check("t4_of_clr", of8, 0); check("t4_uf_clr", uf8, 0);

    // Stop right after an MSB word
    tx_en = 1; tick();
    a = 24'($urandom);
    fp = 1; idata = a[11:0]; qdata = a[23:12]; tick();
    fp = 0; tick();
    s = 24'($urandom);
    fp = 1; idata = s[11:0]; qdata = s[23:12]; tick();
    fp = 0;
    wait_msb("t5_start");
    check("t5_hm", h, msb_w(a[23:12])); check("t5_lm", l, msb_w(a[11:0]));
    tx_en = 0; tick();
    check("t5_hl", h, lsb_w(a[23:12])); check("t5_ll", l, lsb_w(a[11:0]));
    tick();
    check("t5_h0", h, 0); check("t5_l0", l, 0); check("t5_run", run, 0);
    tick();
    check("t5_lvl", lvl, 0);

`ifdef AD_TX_RAMP_EN
    // Ramp source: I counts up from 0, Q is its complement, wrapping at 4095
    ramp_sel = 1; tx_en = 1; tick();
    fp = 1; idata = 0; qdata = 0; tick(); tick();
    fp = 0;
    wait_msb("t6_start");
    for (int k = 0; k < 4100; k++) begin
      logic [6:0] mh, ml;
      logic [11:0] ei;
      ei = 12'(k % 4096);
      mh = h; ml = l;
      tick();
      check("t6_i", {20'd0, ml[5:0], l[5:0]}, {20'd0, ei});
      check("t6_q", {20'd0, mh[5:0], h[5:0]}, {20'd0, 12'(4095 - ei)});
      tick();
    end
    check("t6_uf", uf, 0);
    tx_en = 0; ramp_sel = 0; tick(); tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ad80305_tx_if_ddr_lvds_td.md
Name: ad80305_tx_if_ddr_lvds_td

Overview:
Transmit-side counterpart of the AD80305 DDR LVDS receive interface. It accepts 12-bit I/Q samples from FPGA logic as strobed words and buffers them in a small FIFO. It splits each sample into MSB and LSB 6-bit halves and presents {frame,data} words for the rising (_h) and falling (_l) edges of an external DDR output register. Frame/half mapping matches the receive side: _h carries Q, _l carries I, frame=1 marks the MSB half.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (8 samples)
PRIME_LEVEL, 2, FIFO level required before the first MSB word is sent

Ports:
i_fpga_clk_125p  in   1   sole clock; the DDR output register runs on this clock
i_fpga_rst_125p  in   1   asynchronous reset, active-low
i_tx_en          in   1   transmit enable, level
i_iqdata_fp      in   1   sample strobe; one sample per pulse, at most one per 2 cycles on average
i_idata          in   12  I sample, two's complement, valid with i_iqdata_fp
i_qdata          in   12  Q sample, two's complement, valid with i_iqdata_fp
i_clr_flags      in   1   clears the sticky flags, 1-cycle pulse
o_ddr_h          out  7   {frame, Q half} word for the rising edge
o_ddr_l          out  7   {frame, I half} word for the falling edge
o_fifo_level     out  FIFO_AW+1  current FIFO occupancy
o_underflow      out  1   sticky: a sample slot was sent with FIFO empty
o_overflow       out  1   sticky: a strobe arrived while FIFO full
o_running        out  1   high in RUN state

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, phase=0.
- FIFO:
  - Push on i_iqdata_fp when the FSM is not IDLE and (not full, or a pop occurs in the same cycle).
  - Push while full with no pop: sample dropped, o_overflow set.
  - Simultaneous push and pop on full: both happen, level unchanged.
  - Pointers wrap modulo depth. Level is registered and updated at the same edge as push/pop.
- FSM states:
  - IDLE: o_ddr_h/l = 0, FIFO flushed. i_tx_en=1 -> PRIME.
  - PRIME: accepts pushes; outputs 0. Goes to RUN (phase=0) when level >= PRIME_LEVEL. i_tx_en=0 -> IDLE.
  - RUN, phase 0 edge:
    - If FIFO non-empty: pop the head into r_samp. o_ddr_h <= {1,Q[11:6]}, o_ddr_l <= {1,I[11:6]} from the head. phase->1.
    - If FIFO empty: r_samp=0, words {1,6'd0}, set o_underflow. No stall; the frame cadence is preserved.
  - RUN, phase 1 edge: o_ddr_h <= {0,r_samp Q[5:0]}, o_ddr_l <= {0,r_samp I[5:0]}. phase->0.
  - RUN with i_tx_en=0: the current sample completes. If phase=1, the LSB word is still sent, then IDLE. If phase=0, IDLE immediately. Outputs 0 from the following cycle.
- Frame pattern in RUN is strictly 1,0,1,0 on both _h and _l.
- Output rate is 1 sample per 2 clocks (62.5 MS/s at 125 MHz).
- Latency: the first MSB word appears on o_ddr_* one cycle after the edge where the level reaches PRIME_LEVEL.
- o_ddr_* are registered directly, with no combinational path from inputs. They feed ddio_out datain_h/datain_l.
- Flags:
  - i_clr_flags clears both sticky flags.
  - If a set event and i_clr_flags occur in the same cycle, the set wins.
- Reset asserted mid-RUN: outputs go to 0 immediately (asynchronous), and the FIFO empties.

Optional Feature:
Macro: AD_TX_RAMP_EN.
- Defined:
  - Adds input i_ramp_sel (1 bit).
  - When i_ramp_sel=1 in RUN, FIFO pops are replaced by an internal 12-bit counter: I=cnt, Q=~cnt. The counter increments per sample and wraps 4095->0.
  - No underflow is flagged. Pushes are still accepted into the FIFO.
- Undefined: the port and counter are absent, and behaviour is as above.

Decomposition:
- Shared package ad80305_pkg:
  - IQ_W=12, HALF_W=6, FRAME_MSB=1'b1.
  - FSM state enum {IDLE, PRIME, RUN}.
  - Shared with the receive side.
- One natural sub-module: ad_sync_fifo — single-clock FIFO with level output, parameterised by width (24) and FIFO_AW.

Test Plan:
- Reset, then i_tx_en=1, push I=12'hABC Q=12'h123 and I=12'h456 Q=12'h789 -> RUN entered. Words in order:
  - h=7'h44 l=7'h6A
  - h=7'h23 l=7'h3C
  - h=7'h5E l=7'h51
  - h=7'h09 l=7'h16
- Steady push every 2 cycles for 1000 samples -> no flags set, output sequence equals input sequence, frame strictly alternating.
- Stop pushing after 3 samples -> after they drain, words {1,0}/{0,0}, o_underflow=1, cadence unbroken. i_clr_flags -> 0.
- Push every cycle for 12 cycles with PRIME_LEVEL=8 before RUN -> o_overflow=1, o_fifo_level=8, extra samples dropped.
- Deassert i_tx_en right after an MSB word -> LSB word still sent, then outputs 0, FIFO level 0, o_running=0.
- With AD_TX_RAMP_EN, i_ramp_sel=1 -> successive samples I=0,1,2..., Q=FFF,FFE..., wrapping at 4095.
